// File: rtl/bkg_scroll_ctrl.sv
// -----------------------------------------------------------------------------
// bkg_scroll_ctrl
//   Camera controller for the VGA game display stage. Samples the controller
//   buttons once per frame on screenEnd and moves a scroll position over a
//   multi-page background memory (PAGES pages of ROW_PIXELS x PAGE_ROWS,
//   stacked vertically). Publishes the linear offset the display adds to its
//   pixel address. All state moves on the screenEnd tick, and outputs follow
//   one clock later, so every update lands in vertical blanking.
//
//   Build option: BKG_SCROLL_WRAP_EN
//     defined   -> position limits wrap around (modulo)
//     undefined -> position limits saturate
//
// Ports
//   clk        in   1   system clock
//   reset      in   1   asynchronous, active-high
//   screenEnd  in   1   one-cycle pulse between frames
//   buttons    in   8   [0]up [1]down [2]left [3]right [4]A [7]start
//   bkg_en     out  1   background offset enable (toggled by A)
//   bkg_addr   out  32  ROW_PIXELS*pos_y + pos_x
//   bkg_x      out  8   pos_x
//   bkg_y      out  7   pos_y mod PAGE_ROWS
//   returning  out  1   high while gliding back to origin
// -----------------------------------------------------------------------------
module bkg_scroll_ctrl #(
    parameter int PAGES      = 2,
    parameter int ROW_PIXELS = 160,
    parameter int PAGE_ROWS  = 120,
    parameter int STEP_X     = 1,
    parameter int STEP_Y     = 1,
    parameter int GLIDE      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        screenEnd,
    input  logic [7:0]  buttons,
    output logic        bkg_en,
    output logic [31:0] bkg_addr,
    output logic [7:0]  bkg_x,
    output logic [6:0]  bkg_y,
    output logic        returning
);

    localparam int MAX_ROW = (PAGES - 1) * PAGE_ROWS;
    localparam logic signed [17:0] MAX_Y_S = 18'(MAX_ROW);
    localparam logic signed [9:0]  MAX_X_S = 10'(ROW_PIXELS - 1);

    typedef enum logic {S_IDLE, S_RETURN} state_t;

    logic [7:0]  r_sync1, r_cur, r_prev;
    logic [7:0]  r_pos_x;
    logic [15:0] r_pos_y;
    logic        r_en;
    state_t      r_state;

    state_t             w_state_nxt;
    logic [7:0]         w_press;
    logic [7:0]         w_pos_x_nxt;
    logic [15:0]        w_pos_y_nxt;
    logic               w_en_nxt;
    logic signed [17:0] w_ty;
    logic signed [9:0]  w_tx;

    // 2-flop synchroniser; r_cur is the synchronised button state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_cur   <= '0;
        end else begin
            r_sync1 <= buttons;
            r_cur   <= r_sync1;
        end
    end

    always_comb begin
        w_press     = r_cur & ~r_prev;
        w_state_nxt = r_state;
        w_pos_x_nxt = r_pos_x;
        w_pos_y_nxt = r_pos_y;
        w_en_nxt    = r_en ^ w_press[4];
        w_ty        = $signed({2'b00, r_pos_y});
        w_tx        = $signed({2'b00, r_pos_x});

        case (r_state)
            S_IDLE: begin
                // opposing directions cancel
                if (r_cur[1] && !r_cur[0]) w_ty = w_ty + 18'(STEP_Y);
                if (r_cur[0] && !r_cur[1]) w_ty = w_ty - 18'(STEP_Y);
                if (r_cur[3] && !r_cur[2]) w_tx = w_tx + 10'(STEP_X);
                if (r_cur[2] && !r_cur[3]) w_tx = w_tx - 10'(STEP_X);
`ifdef BKG_SCROLL_WRAP_EN
                if (w_ty < 0)            w_ty = w_ty + MAX_Y_S + 18'sd1;
                else if (w_ty > MAX_Y_S) w_ty = w_ty - MAX_Y_S - 18'sd1;
                if (w_tx < 0)            w_tx = w_tx + MAX_X_S + 10'sd1;
                else if (w_tx > MAX_X_S) w_tx = w_tx - MAX_X_S - 10'sd1;
`else
                if (w_ty < 0)            w_ty = '0;
                else if (w_ty > MAX_Y_S) w_ty = MAX_Y_S;
                if (w_tx < 0)            w_tx = '0;
                else if (w_tx > MAX_X_S) w_tx = MAX_X_S;
`endif
                w_pos_y_nxt = w_ty[15:0];
                // the last row has only its first pixel inside memory bounds
                w_pos_x_nxt = (w_pos_y_nxt == 16'(MAX_ROW)) ? 8'd0 : w_tx[7:0];
                if (w_press[7] && (r_pos_x != 8'd0 || r_pos_y != 16'd0))
                    w_state_nxt = S_RETURN;
            end
            S_RETURN: begin
                w_pos_y_nxt = (r_pos_y > 16'(GLIDE)) ? r_pos_y - 16'(GLIDE) : 16'd0;
                w_pos_x_nxt = (r_pos_x > 8'(GLIDE))  ? r_pos_x - 8'(GLIDE)  : 8'd0;
                if (w_pos_y_nxt == 16'd0 && w_pos_x_nxt == 8'd0)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // frame tick: the only place scroll state moves
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev  <= '0;
            r_pos_x <= '0;
            r_pos_y <= '0;
            r_en    <= 1'b1;
            r_state <= S_IDLE;
        end else if (screenEnd) begin
            r_prev  <= r_cur;
            r_pos_x <= w_pos_x_nxt;
            r_pos_y <= w_pos_y_nxt;
            r_en    <= w_en_nxt;
            r_state <= w_state_nxt;
        end
    end

    // output stage; follows the tick by one clock and then holds all frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bkg_en    <= 1'b1;
            bkg_addr  <= '0;
            bkg_x     <= '0;
            bkg_y     <= '0;
            returning <= 1'b0;
        end else begin
            bkg_en    <= r_en;
            bkg_addr  <= 32'(r_pos_y) * 32'(ROW_PIXELS) + 32'(r_pos_x);
            bkg_x     <= r_pos_x;
            bkg_y     <= 7'(32'(r_pos_y) % 32'(PAGE_ROWS));
            returning <= (r_state == S_RETURN);
        end
    end

endmodule

// File: tb/tb_bkg_scroll_ctrl.sv
module tb_bkg_scroll_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        screenEnd = 1'b0;
    logic [7:0]  buttons = 8'h00;
    logic        bkg_en;
    logic [31:0] bkg_addr;
    logic [7:0]  bkg_x;
    logic [6:0]  bkg_y;
    logic        returning;

    bkg_scroll_ctrl dut (
        .clk(clk), .reset(reset), .screenEnd(screenEnd), .buttons(buttons),
        .bkg_en(bkg_en), .bkg_addr(bkg_addr), .bkg_x(bkg_x), .bkg_y(bkg_y),
        .returning(returning)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x; int y; int addr; int en; int ret;
    } exp_t;

    exp_t q[$];
    exp_t cur_e;
    int   n_chk = 0;
    int   n_fail = 0;

    // reference model state
    int         mx, my, men, mret;
    logic [7:0] mprev;

    localparam int UP = 1, DN = 2, LF = 4, RT = 8, BA = 16, ST = 128;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".x"},    32'(bkg_x),     32'(e.x));
        chk({tag, ".y"},    32'(bkg_y),     32'(e.y % 120));
        chk({tag, ".addr"}, bkg_addr,       32'(e.addr));
        chk({tag, ".en"},   32'(bkg_en),    32'(e.en));
        chk({tag, ".ret"},  32'(returning), 32'(e.ret));
    endtask

    task automatic model_reset();
        mx = 0; my = 0; men = 1; mret = 0; mprev = 8'h00;
        cur_e = '{x:0, y:0, addr:0, en:1, ret:0};
        q.delete();
    endtask

    task automatic model_step(input logic [7:0] b);
        logic [7:0] press;
        int ox, oy;
        press = b & ~mprev;
        mprev = b;
        if (mret == 0) begin
            ox = mx; oy = my;
            if (b[1] && !b[0]) my = my + 1;
            if (b[0] && !b[1]) my = my - 1;
            if (b[3] && !b[2]) mx = mx + 1;
            if (b[2] && !b[3]) mx = mx - 1;
`ifdef BKG_SCROLL_WRAP_EN
            if (my < 0) my = my + 121; else if (my > 120) my = my - 121;
            if (mx < 0) mx = mx + 160; else if (mx > 159) mx = mx - 160;
`else
            if (my < 0) my = 0; else if (my > 120) my = 120;
            if (mx < 0) mx = 0; else if (mx > 159) mx = 159;
`endif
            if (my == 120) mx = 0;
            if (press[7] && (ox != 0 || oy != 0)) mret = 1;
        end else begin
            my = my - ((my < 4) ? my : 4);
            mx = mx - ((mx < 4) ? mx : 4);
            if (mx == 0 && my == 0) mret = 0;
        end
        if (press[4]) men = 1 - men;
    endtask

    // one frame: settle buttons through the synchroniser, pulse screenEnd,
    // confirm nothing moves at the first edge and the result lands at the second
    task automatic frame(input logic [7:0] b);
        exp_t e;
        @(posedge clk); #1 buttons = b;
        repeat (2) @(posedge clk);
        #1 screenEnd = 1'b1;
        model_step(b);
        e = '{x:mx, y:my, addr:160*my+mx, en:men, ret:mret};
        q.push_back(e);
        @(posedge clk); #1 screenEnd = 1'b0;
        chk_all("hold", cur_e);
        @(posedge clk); #1;
        cur_e = q.pop_front();
        chk_all("frame", cur_e);
    endtask

    task automatic do_reset();
        @(posedge clk); #3 reset = 1'b1; buttons = 8'h00;
        #1 model_reset();
        chk_all("reset", cur_e);
        @(posedge clk); #1 reset = 1'b0;
    endtask

    initial begin
        model_reset();
        // 1: reset before any edge, then mid-frame after motion
        #2 reset = 1'b1;
        #1 chk_all("reset0", cur_e);
        @(posedge clk); #1 reset = 1'b0;

        // 2: hold down 5 frames
        repeat (5) frame(8'(DN));
        chk("down5.y", 32'(bkg_y), 32'd5);
        chk("down5.addr", bkg_addr, 32'd800);
        // button activity without screenEnd changes nothing
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1 buttons = 8'(i * 37 + 1);
        end
        @(posedge clk); #1 buttons = 8'(DN);
        repeat (3) @(posedge clk);
        #1 chk_all("nose", cur_e);
        chk("nose.addr", bkg_addr, 32'd800);
        frame(8'(RT));
        do_reset();

        // 3: up from 0 saturates; down to last row and beyond
        frame(8'(UP));
`ifndef BKG_SCROLL_WRAP_EN
        chk("up0.y", 32'(bkg_y), 32'd0);
`else
        chk("up0.addr", bkg_addr, 32'd19200);
`endif
        do_reset();
        frame(8'(RT));
        frame(8'(RT));
        repeat (119) frame(8'(DN));
        chk("y119", 32'(bkg_y), 32'd119);
        repeat (3) frame(8'(DN | RT));
        chk("maxrow.y", 32'(bkg_y), 32'd0);
        chk("maxrow.addr", bkg_addr, 32'd19200);
        frame(8'(RT));
        chk("maxrow.x", 32'(bkg_x), 32'd0);
        frame(8'(UP | DN | LF | RT));
        do_reset();

        // 4: glide back from (10,6), direction buttons ignored
        repeat (6) frame(8'(DN));
        repeat (10) frame(8'(RT));
        frame(8'h00);
        frame(8'(ST));
        chk("ret.on", 32'(returning), 32'd1);
        frame(8'(DN));
        chk("g1.x", 32'(bkg_x), 32'd6);
        chk("g1.y", 32'(bkg_y), 32'd2);
        frame(8'(DN | ST));
        chk("g2.x", 32'(bkg_x), 32'd2);
        frame(8'h00);
        chk("g3.ret", 32'(returning), 32'd0);
        chk("g3.addr", bkg_addr, 32'd0);
        frame(8'(DN));
        chk("idle.y", 32'(bkg_y), 32'd1);
        // reset mid-glide
        repeat (2) frame(8'(DN));
        frame(8'(ST));
        do_reset();
        frame(8'h00);

        // 5: A toggles once per press
        repeat (4) frame(8'(BA));
        chk("a.en0", 32'(bkg_en), 32'd0);
        frame(8'h00);
        frame(8'(BA));
        chk("a.en1", 32'(bkg_en), 32'd1);
        frame(8'h00);
        frame(8'(BA | ST));
        chk("as.en", 32'(bkg_en), 32'd0);
        chk("as.ret", 32'(returning), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
